// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for alu_mc and the decode stage.
// Opcode values are the team's 6-bit instruction encodings.
package alu_pkg;

    localparam int OP_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'h00,
        OP_ADDI = 6'h01,
        OP_SUB  = 6'h02,
        OP_SUBI = 6'h03,
        OP_MUL  = 6'h04,
        OP_MULI = 6'h05,
        OP_OR   = 6'h06,
        OP_ORI  = 6'h07,
        OP_AND  = 6'h08,
        OP_ANDI = 6'h09,
        OP_XOR  = 6'h0A,
        OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C,
        OP_STW  = 6'h0D
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULI);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_STW;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock,
// WIDTH iterations after start, full 2*WIDTH-bit product on the done cycle.
module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_o = acc_step;
    assign busy_o    = busy_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; busy_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops register in one clock, multiplies run on
// alu_mul_seq; valid/ready on both sides with a single result register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] addr,
    output logic             ovf,
    output logic             zero,
    output logic             err
);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   rd_q, rd_d, addr_q, addr_d;
    logic               ovf_q, ovf_d, zero_q, err_q, err_d;
    logic               load, fire;
    logic [WIDTH-1:0]   opb, sum, diff, ea;
    logic [WIDTH-1:0]   alu_rd, alu_addr;
    logic               alu_ovf, alu_err, add_ovf, sub_ovf;
    logic               mul_done, mul_busy;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    // Odd opcodes up to XORI take the immediate as second operand.
    assign opb     = op[0] ? imm : rt;
    assign sum     = rs + opb;
    assign diff    = rs - opb;
    assign ea      = rs + imm;
    assign add_ovf = (rs[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
    assign sub_ovf = (rs[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);

    always_comb begin
        alu_rd   = '0;
        alu_addr = '0;
        alu_ovf  = 1'b0;
        alu_err  = !is_legal(op);
        case (op)
            OP_ADD, OP_ADDI: begin alu_rd = sum;  alu_ovf = add_ovf; end
            OP_SUB, OP_SUBI: begin alu_rd = diff; alu_ovf = sub_ovf; end
            OP_OR,  OP_ORI:  alu_rd = rs | opb;
            OP_AND, OP_ANDI: alu_rd = rs & opb;
            OP_XOR, OP_XORI: alu_rd = rs ^ opb;
            OP_LDW:          alu_addr = ea;
            OP_STW:          begin alu_addr = ea; alu_rd = rt; end
            default:         alu_rd = '0;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rd_d    = alu_rd;
        addr_d  = alu_addr;
        ovf_d   = alu_ovf;
        err_d   = alu_err;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (is_mul(op)) state_d = MUL;
                    else            load    = 1'b1;
                end
            end
            MUL: begin
                if (mul_done) begin
                    load    = 1'b1;
                    rd_d    = mul_prod[WIDTH-1:0];
                    addr_d  = '0;
                    ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = load || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                rd_q   <= rd_d;
                addr_q <= addr_d;
                ovf_q  <= ovf_d;
                zero_q <= (rd_d == '0);
                err_q  <= err_d;
            end
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (fire && is_mul(op)),
        .a_i      (rs),
        .b_i      (opb),
        .done_o   (mul_done),
        .product_o(mul_prod),
        .busy_o   (mul_busy)
    );

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32 and WIDTH=8: directed vector table, hand
// sequences for back-to-back, back-pressure and mid-multiply reset, random ops.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel8;
    logic        in_valid, out_ready;
    logic [5:0]  op_s;
    logic [31:0] rs_s, rt_s, imm_s;

    logic        ir32, ov32, ovf32, zero32, err32;
    logic [31:0] rd32, addr32;
    logic        ir8, ov8, ovf8, zero8, err8;
    logic [7:0]  rd8, addr8;

    logic        in_ready, out_valid, ovf, zero, err;
    logic [31:0] rd, addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel8), .in_ready(ir32),
        .op(op_s), .rs(rs_s), .rt(rt_s), .imm(imm_s),
        .out_valid(ov32), .out_ready(out_ready), .rd(rd32), .addr(addr32),
        .ovf(ovf32), .zero(zero32), .err(err32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel8), .in_ready(ir8),
        .op(op_s), .rs(rs_s[7:0]), .rt(rt_s[7:0]), .imm(imm_s[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .rd(rd8), .addr(addr8),
        .ovf(ovf8), .zero(zero8), .err(err8)
    );

    assign in_ready  = sel8 ? ir8  : ir32;
    assign out_valid = sel8 ? ov8  : ov32;
    assign rd        = sel8 ? {24'd0, rd8}   : rd32;
    assign addr      = sel8 ? {24'd0, addr8} : addr32;
    assign ovf       = sel8 ? ovf8  : ovf32;
    assign zero      = sel8 ? zero8 : zero32;
    assign err       = sel8 ? err8  : err32;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] addr;
        logic        ovf;
        logic        err;
    } res_t;

    typedef struct {
        int          w;
        logic [5:0]  op;
        logic [31:0] rs, rt, imm;
        logic [31:0] rd, addr;
        logic        ovf, zero, err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint to_signed(input int w, input longint unsigned v);
        if (v[w-1]) return longint'(v) - (longint'(1) <<< w);
        return longint'(v);
    endfunction

    // Reference: plain wide-integer arithmetic, masked to the datapath width.
    function automatic res_t model(input int w, input logic [5:0] o,
                                   input logic [31:0] a, input logic [31:0] t,
                                   input logic [31:0] im);
        res_t r;
        longint unsigned mask, ua, ub, ut, ui, p;
        longint s, smax, smin;
        r    = '0;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a}  & mask;
        ut   = {32'd0, t}  & mask;
        ui   = {32'd0, im} & mask;
        ub   = o[0] ? ui : ut;
        smax = (longint'(1) <<< (w - 1)) - 1;
        smin = -(longint'(1) <<< (w - 1));
        case (o)
            6'h00, 6'h01: begin
                r.rd  = 32'((ua + ub) & mask);
                s     = to_signed(w, ua) + to_signed(w, ub);
                r.ovf = (s > smax) || (s < smin);
            end
            6'h02, 6'h03: begin
                r.rd  = 32'((ua - ub) & mask);
                s     = to_signed(w, ua) - to_signed(w, ub);
                r.ovf = (s > smax) || (s < smin);
            end
            6'h04, 6'h05: begin
                p     = ua * ub;
                r.rd  = 32'(p & mask);
                r.ovf = (p >> w) != 0;
            end
            6'h06, 6'h07: r.rd = 32'(ua | ub);
            6'h08, 6'h09: r.rd = 32'(ua & ub);
            6'h0A, 6'h0B: r.rd = 32'(ua ^ ub);
            6'h0C: r.addr = 32'((ua + ui) & mask);
            6'h0D: begin
                r.addr = 32'((ua + ui) & mask);
                r.rd   = 32'(ut);
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Called on a falling edge; returns there with the result visible.
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] im, output int lat, output int rlow);
        int n;
        op_s = o; rs_s = a; rt_s = t; imm_s = im;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        rlow = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) rlow++;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vt[16];

    initial begin
        int   lat, rlow, nv;
        res_t e;
        logic [5:0]  bo[5];
        logic [31:0] ba[5], bt[5], bi[5];

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, rlow, nv, w;
        res_t e;
        logic [5:0]  o;
        logic [31:0] a, t, im;
        logic [5:0]  bo[5];
        logic [31:0] ba[5], bt[5], bi[5];

        vt[0]  = '{32, 6'h00, 32'h5,        32'hFFFFFFFE, 32'h0,        32'h3,        32'h0,   1'b0, 1'b0, 1'b0, 1};
        vt[1]  = '{32, 6'h00, 32'h7FFFFFFF, 32'h1,        32'h0,        32'h80000000, 32'h0,   1'b1, 1'b0, 1'b0, 1};
        vt[2]  = '{32, 6'h03, 32'h7,        32'h0,        32'h7,        32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1};
        vt[3]  = '{32, 6'h04, 32'h10000,    32'h10001,    32'h0,        32'h10000,    32'h0,   1'b1, 1'b0, 1'b0, 33};
        vt[4]  = '{32, 6'h05, 32'h6,        32'h0,        32'h7,        32'h2A,       32'h0,   1'b0, 1'b0, 1'b0, 33};
        vt[5]  = '{32, 6'h0C, 32'h100,      32'h0,        32'h24,       32'h0,        32'h124, 1'b0, 1'b1, 1'b0, 1};
        vt[6]  = '{32, 6'h0D, 32'h100,      32'hAB,       32'h4,        32'hAB,       32'h104, 1'b0, 1'b0, 1'b0, 1};
        vt[7]  = '{32, 6'h3F, 32'h1,        32'h2,        32'h3,        32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 1};
        vt[8]  = '{32, 6'h02, 32'h80000000, 32'h1,        32'h0,        32'h7FFFFFFF, 32'h0,   1'b1, 1'b0, 1'b0, 1};
        vt[9]  = '{32, 6'h0B, 32'hFFFF0000, 32'h0,        32'hFFFFFFFF, 32'h0000FFFF, 32'h0,   1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{32, 6'h02, 32'h0,        32'h80000000, 32'h0,        32'h80000000, 32'h0,   1'b1, 1'b0, 1'b0, 1};
        vt[11] = '{32, 6'h04, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        32'h0,   1'b1, 1'b0, 1'b0, 33};
        vt[12] = '{32, 6'h09, 32'hFFFF,     32'h0,        32'h0,        32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1};
        vt[13] = '{8,  6'h04, 32'd15,       32'd17,       32'h0,        32'hFF,       32'h0,   1'b0, 1'b0, 1'b0, 9};
        vt[14] = '{8,  6'h05, 32'd16,       32'h0,        32'd16,       32'h0,        32'h0,   1'b1, 1'b1, 1'b0, 9};
        vt[15] = '{8,  6'h00, 32'h7F,       32'h1,        32'h0,        32'h80,       32'h0,   1'b1, 1'b0, 1'b0, 1};

        rst_n = 1'b0; sel8 = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_s = 6'h0; rs_s = '0; rt_s = '0; imm_s = '0;
        #3;
        check("reset out_valid", out_valid, 0);
        check("reset rd", rd, 0);
        check("reset addr", addr, 0);
        check("reset ovf", ovf, 0);
        check("reset zero", zero, 0);
        check("reset err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            sel8 = (vt[i].w == 8);
            issue(vt[i].op, vt[i].rs, vt[i].rt, vt[i].imm, lat, rlow);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d rd", i), rd, vt[i].rd);
            check($sformatf("vec%0d addr", i), addr, vt[i].addr);
            check($sformatf("vec%0d ovf", i), ovf, vt[i].ovf);
            check($sformatf("vec%0d zero", i), zero, vt[i].zero);
            check($sformatf("vec%0d err", i), err, vt[i].err);
            check($sformatf("vec%0d latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d in_ready low cycles", i), rlow, vt[i].lat - 1);
        end

        // Back-to-back single-cycle ops: one result per clock.
        sel8 = 1'b0;
        @(negedge clk);
        bo = '{6'h09, 6'h07, 6'h0A, 6'h0C, 6'h0D};
        ba = '{32'hF0F0, 32'hF000, 32'hFF00, 32'h100, 32'h200};
        bt = '{32'h0, 32'h0, 32'h0FF0, 32'h0, 32'hAB};
        bi = '{32'hFF, 32'h0F, 32'h0, 32'h24, 32'h8};
        out_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                e = model(32, bo[k-1], ba[k-1], bt[k-1], bi[k-1]);
                check($sformatf("b2b%0d out_valid", k - 1), out_valid, 1);
                check($sformatf("b2b%0d rd", k - 1), rd, e.rd);
                check($sformatf("b2b%0d addr", k - 1), addr, e.addr);
            end
            if (k < 5) begin
                op_s = bo[k]; rs_s = ba[k]; rt_s = bt[k]; imm_s = bi[k];
                in_valid = 1'b1;
                #1;
                check($sformatf("b2b%0d in_ready", k), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Back-pressure: result held, nothing accepted, then drain and accept together.
        out_ready = 1'b0;
        op_s = 6'h00; rs_s = 32'h10; rt_s = 32'h20; imm_s = 32'h0;
        in_valid = 1'b1;
        @(negedge clk);
        op_s = 6'h07; rs_s = 32'h1; rt_s = 32'h0; imm_s = 32'h6;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d in_ready", c), in_ready, 0);
            check($sformatf("bp%0d out_valid", c), out_valid, 1);
            check($sformatf("bp%0d rd stable", c), rd, 32'h30);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp queued out_valid", out_valid, 1);
        check("bp queued rd", rd, 32'h7);
        @(negedge clk);
        check("bp drained out_valid", out_valid, 0);

        // Reset in the middle of a multiply.
        issue(6'h00, 32'h7FFFFFFF, 32'h1, 32'h0, lat, rlow);
        op_s = 6'h04; rs_s = 32'h3; rt_s = 32'h5; imm_s = 32'h0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst rd", rd, 0);
        check("midrst addr", addr, 0);
        check("midrst ovf", ovf, 0);
        check("midrst zero", zero, 0);
        check("midrst err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready after release", in_ready, 1);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("midrst discarded multiply", nv, 0);
        issue(6'h3F, 32'h12, 32'h34, 32'h56, lat, rlow);
        check("illegal err", err, 1);
        check("illegal rd", rd, 0);
        check("illegal latency", lat, 1);

        // Random ops on both widths against the reference model.
        for (int i = 0; i < 60; i++) begin
            w    = ($urandom_range(0, 1) == 0) ? 8 : 32;
            sel8 = (w == 8);
            o    = 6'($urandom_range(0, 15));
            if (o == 6'd14)      o = 6'h3F;
            else if (o == 6'd15) o = 6'($urandom_range(14, 62));
            a  = $urandom;
            t  = $urandom;
            im = $urandom;
            if ($urandom_range(0, 3) == 0) a  = a & 32'hF;
            if ($urandom_range(0, 3) == 0) im = a;
            e = model(w, o, a, t, im);
            issue(o, a, t, im, lat, rlow);
            check($sformatf("rand%0d op%0h w%0d rd", i, o, w), rd, e.rd);
            check($sformatf("rand%0d op%0h w%0d addr", i, o, w), addr, e.addr);
            check($sformatf("rand%0d op%0h w%0d ovf", i, o, w), ovf, e.ovf);
            check($sformatf("rand%0d op%0h w%0d zero", i, o, w), zero, e.rd == 0);
            check($sformatf("rand%0d op%0h w%0d err", i, o, w), err, e.err);
            check($sformatf("rand%0d op%0h w%0d latency", i, o, w), lat,
                  (o == 6'h04 || o == 6'h05) ? w + 1 : 1);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with valid/ready handshakes on its input and result sides. It executes the team's 6-bit opcode set, including LDW/STW address generation. Single-cycle ops complete in one clock; MUL/MULI run on an iterative shift-add multiplier. It sits between the decode stage and writeback/memory-address logic, and back-pressures decode while a multiply is in flight.

## Interface
Parameters:
- WIDTH, 32: datapath width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH+1): width of the multiplier iteration counter (derived).

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  ALU can accept an operation this cycle.
- op  in  6  opcode (encodings defined in alu_pkg).
- rs, rt, imm  in  WIDTH  source operands and immediate (two's complement).
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- rd  out  WIDTH  data result.
- addr  out  WIDTH  effective address (LDW/STW only; 0 otherwise).
- ovf  out  1  overflow flag.
- zero  out  1  rd == 0.
- err  out  1  illegal opcode.

## Operation
Opcodes:
- 0x00 ADD: rs+rt
- 0x01 ADDI: rs+imm
- 0x02 SUB: rs-rt
- 0x03 SUBI: rs-imm
- 0x04 MUL: rs*rt
- 0x05 MULI: rs*imm
- 0x06 OR / 0x07 ORI
- 0x08 AND / 0x09 ANDI
- 0x0A XOR / 0x0B XORI
- 0x0C LDW: addr=rs+imm, rd=0
- 0x0D STW: addr=rs+imm, rd=rt
- Any other opcode: rd=0, addr=0, err=1.

Arithmetic and flag rules:
- All sums are modulo 2^WIDTH.
- ADD/SUB ovf is signed overflow: operand signs equal (ADD) or differ (SUB), and the result sign differs from rs.
- MUL is unsigned. rd is the low WIDTH bits of the 2·WIDTH product; ovf=1 when the high WIDTH bits are non-zero.
- ovf=0 for logic ops, LDW, STW and illegal opcodes.
- zero is derived from rd for every op.

Handshake and state machine:
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- A transfer occurs on a cycle where in_valid && in_ready.
- States are IDLE and MUL; reset enters IDLE.
- IDLE, non-MUL op accepted: result registered on the same edge; stays IDLE.
- IDLE, MUL/MULI accepted: latch multiplicand, multiplier and a 2·WIDTH accumulator (cleared); cnt=0; go to MUL.
- MUL, each cycle: if multiplier bit 0 is set, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right; cnt++.
- MUL, on the cycle cnt==WIDTH-1: load the result register, set out_valid, return to IDLE.
- Output register: cleared when out_valid && out_ready and no new load occurs that cycle. A load and a drain in the same cycle leaves out_valid=1 with the new result.
- out_valid can only be 0 when a MUL completes, so the completion never stalls.
- Output fields are stable while out_valid && !out_ready.
- Inputs are sampled only at a transfer; op, rs, rt and imm may change freely otherwise.

Reset (asynchronous, mid-operation included):
- state=IDLE, cnt=0, out_valid=0.
- rd, addr, ovf, zero and err are all 0 (zero is forced 0 during reset).
- An in-flight multiply is discarded with no output.
- in_ready is 1 on the first cycle after reset deasserts.

## Timing
- Non-MUL op, transfer at edge N: out_valid=1 after edge N, i.e. latency 1.
- MUL/MULI, transfer at edge N: out_valid=1 after edge N+WIDTH, i.e. latency WIDTH+1.
- in_ready is 0 for WIDTH cycles while in MUL.
- Throughput:
  - Single-cycle ops: 1 per cycle with out_ready held at 1.
  - Multiplies: one per WIDTH+1 cycles.
- With out_ready=0 and out_valid=1, in_ready=0, so no op is accepted and nothing is lost.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists; all data outputs are registered.

## Structure
- alu_pkg holds the following; decode uses the same package:
  - op_e enum of the 14 opcodes.
  - state_e (IDLE, MUL).
  - is_mul(op) and is_legal(op) helper functions.
- Sub-module alu_mul_seq contains the shift-add iterator:
  - Inputs: start, a, b.
  - Outputs: done, the 2·WIDTH product, busy.
  - alu_mc instantiates one and owns the handshake and the result register.

## Test plan
- Reset, then ADD rs=5, rt=0xFFFFFFFE (WIDTH=32), out_ready=1 -> next cycle rd=3, ovf=0, zero=0.
- ADD 0x7FFFFFFF+1 -> rd=0x80000000, ovf=1. SUBI rs=7, imm=7 -> rd=0, zero=1, ovf=0.
- MUL rs=0x10000, rt=0x10001 -> in_ready=0 for 32 cycles; out_valid exactly 33 cycles after the transfer; rd=0x10000, ovf=1. MULI 6×7 -> rd=42, ovf=0.
- Back-to-back ANDI/ORI/XOR/LDW/STW with out_ready=1 -> one result per cycle. LDW rs=0x100, imm=0x24 -> addr=0x124, rd=0. STW rt=0xAB -> rd=0xAB.
- Hold out_ready=0 after one result for 5 cycles -> in_ready=0; rd stable; no new op accepted. Release -> a queued op is accepted on the same cycle as the drain.
- Assert rst_n=0 at MUL iteration 10 -> out_valid=0 and all outputs 0 immediately. After release, op=0x3F -> err=1, rd=0, latency 1. Rerun with WIDTH=8: MUL 15×17 -> rd=0xFF after 9 cycles.
